// File: rtl/seq_mult_shift_add.sv
// seq_mult_shift_add
// Iterative unsigned shift-and-add multiplier. One multiplier bit is retired per
// clock. A WIDTH-bit add with carry-out feeds a right shift of the {hi, lo}
// accumulator, so the full 2*WIDTH-bit product is formed without overflow.
// A product takes exactly WIDTH CALC cycles, whatever the operand values.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        a/b operand pair valid
//   in_ready   out  1        operands accepted (IDLE only)
//   a          in   WIDTH    multiplicand, unsigned
//   b          in   WIDTH    multiplier, unsigned
//   out_valid  out  1        product valid (DONE only)
//   out_ready  in   1        downstream takes the product
//   product    out  2*WIDTH  a*b, registered
//   busy       out  1        high in CALC and DONE
module seq_mult_shift_add #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;  // {carry-out, sum}
    logic               accept;
    logic               step;
    logic               last_step;

    assign accept    = (state_q == StIdle) && in_valid;
    assign step      = (state_q == StCalc);
    assign last_step = step && (cnt_q == CntLast);

    assign addend = lo_q[0] ? m_q : '0;
    assign sum    = {1'b0, hi_q} + {1'b0, addend};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StCalc;
            StCalc:  if (last_step) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs, decoded from registered state only
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        product   = product_q;
    end

    // Datapath next state
    always_comb begin
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (accept) begin
            m_d   = a;
            hi_d  = '0;
            lo_d  = b;
            cnt_d = '0;
        end else if (step) begin
            // Shift right by one with the carry-out entering the MSB.
            hi_d      = sum[WIDTH:1];
            lo_d      = {sum[0], lo_q[WIDTH-1:1]};
            cnt_d     = cnt_q + 1'b1;
            product_d = {sum, lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Scoreboard bench for seq_mult_shift_add (WIDTH=32). The driver pushes the
// expected product and accept cycle when an operand handshake is seen; the
// monitor pops and compares whenever the DUT presents a product.
module tb_seq_mult_shift_add;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] product;
    logic           busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];
    logic           ov_prev = 1'b0;
    logic           b2b = 1'b0;
    int             last_rise = -1;

    seq_mult_shift_add #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    // Monitor: runs 1 time unit after each falling edge, after the driver.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    check("latency", 64'(cyc - acc_q.pop_front()), 64'(W));
                end
                if (b2b && last_rise >= 0) check("b2b_spacing", 64'(cyc - last_rise), 64'(W + 2));
                last_rise = cyc;
            end
            if (out_valid) begin
                check("done_in_ready", {63'd0, in_ready}, 64'd0);
                check("done_busy", {63'd0, busy}, 64'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_product", 64'd1, 64'd0);
                end else if (out_ready) begin
                    check("product", product, exp_q.pop_front());
                end else begin
                    check("stall_product", product, exp_q[0]);
                end
            end
        end
        ov_prev = out_valid;
    end

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2*W-1:0] ev, input bit keep);
        int n = 0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            exp_q.push_back(ev);
            acc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    logic [W-1:0] b2b_a [3] = '{32'h0000FFFF, 32'h00000003, 32'h80000000};
    logic [W-1:0] b2b_b [3] = '{32'h00010001, 32'h00000005, 32'h00000002};

    initial begin
        int n;
        // Reset state
        #3;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        issue(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, 1'b0);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0);
        issue(32'h12345678, 32'h00000000, 64'h0000000000000000, 1'b0);
        issue(32'h00000123, 32'h00000123, 64'h0000000000014AC9, 1'b0);
        issue(32'hDEADBEEF, 32'h00000001, 64'h00000000DEADBEEF, 1'b0);
        drain();

        // Back-pressure in DONE, with ignored in_valid pulses
        out_ready = 1'b0;
        issue(32'h0000000A, 32'h0000000B, 64'h000000000000006E, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 32'h55555555;
            b = 32'h33333333;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_still_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        #2;
        check("bp_in_ready_after", {63'd0, in_ready}, 64'd1);
        check("bp_out_valid_after", {63'd0, out_valid}, 64'd0);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);

        // Reset 10 cycles into CALC
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_product", product, 64'd0);
        exp_q.delete();
        acc_q.delete();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_idle", {63'd0, in_ready}, 64'd1);
        issue(32'h00000420, 32'h00000002, 64'h0000000000000840, 1'b0);
        drain();

        // Back-to-back with in_valid held, checked against a*b
        b2b = 1'b1;
        last_rise = -1;
        for (int i = 0; i < 3; i++) begin
            issue(b2b_a[i], b2b_b[i], {32'd0, b2b_a[i]} * {32'd0, b2b_b[i]}, i < 2);
        end
        in_valid = 1'b0;
        drain();
        b2b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
